// File: rtl/mo_mul_pkg.sv
// Shared constants for the Montgomery multiplier: the Kyber and Dilithium
// modulus settings and a helper that derives Q from (Q_M, Q_K).
package mo_mul_pkg;

  localparam int KYBER_Q_M     = 8;
  localparam int KYBER_Q_K     = 13;
  localparam int KYBER_W       = 12;
  localparam int KYBER_R_MOD_Q = 767;

  localparam int DIL_Q_M       = 13;
  localparam int DIL_Q_K       = 1023;
  localparam int DIL_W         = 23;
  localparam int DIL_R_MOD_Q   = 8191;

  // Q = Q_K * 2^Q_M + 1
  function automatic int mo_mul_q(input int q_m, input int q_k);
    return q_k * (1 << q_m) + 1;
  endfunction

endpackage

// File: rtl/mo_mul_stage.sv
// One combinational radix-2 Montgomery step: d_next = (d + b[I]*a [- Q]) / 2,
// with the subtraction of Q split into a high-part subtract of Q_K and a final -1.
module mo_mul_stage #(
  parameter int Q_M = 8,
  parameter int Q_K = 13,
  parameter int W   = 12,
  parameter int I   = 0
) (
  input  logic signed [W:0]   d,
  input  logic        [W-1:0] a,
  input  logic        [W-1:0] b,
  output logic signed [W:0]   d_next
);

  localparam int HW = W + 2 - Q_M;
  localparam logic [HW-1:0] QK_V = HW'(Q_K);

  logic [W+1:0]  t_add;
  logic [W+1:0]  t_sub;
  logic [HW-1:0] t_hi;
  logic          unused_bits;

  always_comb begin
    t_add  = {d[W], d} + (b[I] ? {2'b00, a} : '0);
    // Q = Q_K*2^Q_M + 1, so only the bits at and above Q_M see Q_K.
    t_hi   = t_add[W+1:Q_M] - QK_V;
    t_sub  = {t_hi, t_add[Q_M-1:0]} - (W+2)'(1);
    d_next = t_add[0] ? t_sub[W+1:1] : t_add[W+1:1];
  end

  // Only b[I] matters here; t_sub[0] is always 0 after an odd subtract.
  assign unused_bits = ^{b, t_sub[0]};

endmodule

// File: rtl/mo_mul_pipe.sv
// Fully pipelined radix-2 Montgomery multiplier: W step stages, a tag/valid
// chain alongside the data and an optional canonicalising output register.
module mo_mul_pipe
  import mo_mul_pkg::*;
#(
  parameter int Q_M   = 8,
  parameter int Q_K   = 13,
  parameter int W     = 12,
  parameter int TAG_W = 8,
  parameter int NORM  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W:0]         out_data,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int WP1 = W + 1;
  localparam logic [W:0] Q_V = WP1'(mo_mul_q(Q_M, Q_K));

  // Handshake: a token moves on a cycle where valid & ready. The whole pipe
  // advances together on en; when the output is stalled every register holds,
  // so bubbles are kept and ordering is strict FIFO.
  logic en;

  logic                v_q   [0:W];
  logic [TAG_W-1:0]    tag_q [0:W];
  logic [W-1:0]        a_q   [0:W-1];
  logic [W-1:0]        b_q   [0:W-1];
  logic signed [W:0]   d_q   [1:W];

  logic signed [W:0]   d_cur [0:W-1];
  logic signed [W:0]   d_nxt [0:W-1];

  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  for (genvar k = 0; k < W; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign d_cur[k] = '0;
    end else begin : g_rest
      assign d_cur[k] = d_q[k];
    end

    mo_mul_stage #(
      .Q_M (Q_M),
      .Q_K (Q_K),
      .W   (W),
      .I   (k)
    ) u_stage (
      .d      (d_cur[k]),
      .a      (a_q[k]),
      .b      (b_q[k]),
      .d_next (d_nxt[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= W; k++) begin
        v_q[k]   <= 1'b0;
        tag_q[k] <= '0;
      end
      for (int k = 0; k < W; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      for (int k = 1; k <= W; k++) begin
        d_q[k] <= '0;
      end
    end else if (en) begin
      v_q[0]   <= in_valid;
      tag_q[0] <= in_tag;
      a_q[0]   <= in_a;
      b_q[0]   <= in_b;
      for (int k = 1; k <= W; k++) begin
        v_q[k]   <= v_q[k-1];
        tag_q[k] <= tag_q[k-1];
        d_q[k]   <= d_nxt[k-1];
      end
      for (int k = 1; k < W; k++) begin
        a_q[k] <= a_q[k-1];
        b_q[k] <= b_q[k-1];
      end
    end
  end

  if (NORM != 0) begin : g_norm
    logic             n_v;
    logic [W:0]       n_d;
    logic [TAG_W-1:0] n_tag;

    // d_W lies in (-Q,Q); a single conditional add of Q makes it canonical.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        n_v   <= 1'b0;
        n_d   <= '0;
        n_tag <= '0;
      end else if (en) begin
        n_v   <= v_q[W];
        n_d   <= d_q[W][W] ? (d_q[W] + Q_V) : d_q[W];
        n_tag <= tag_q[W];
      end
    end

    assign out_valid = n_v;
    assign out_data  = n_d;
    assign out_tag   = n_tag;
  end else begin : g_raw
    assign out_valid = v_q[W];
    assign out_data  = d_q[W];
    assign out_tag   = tag_q[W];
  end

endmodule

// File: tb/tb_mo_mul_pipe.sv
// Directed bench for mo_mul_pipe: Kyber (NORM=1), Dilithium (NORM=1) and
// Kyber NORM=0 instances, checked against hand-computed values and a small model.
module tb_mo_mul_pipe;
  import mo_mul_pkg::*;

  localparam int KQ = 3329;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic longint mont_ref(input longint a, input longint b,
                                      input longint q, input int w);
    longint r;
    r = (a * b) % q;
    for (int i = 0; i < w; i++) r = ((r % 2) != 0) ? (r + q) / 2 : r / 2;
    return r;
  endfunction

  // ---------------- Kyber, NORM=1 ----------------
  logic        k_in_valid = 1'b0;
  logic        k_in_ready;
  logic [11:0] k_in_a = '0, k_in_b = '0;
  logic [7:0]  k_in_tag = '0;
  logic        k_out_valid, k_out_ready;
  logic [12:0] k_out_data;
  logic [7:0]  k_out_tag;
  logic        bp_mode = 1'b0, bp_rdy = 1'b0;
  logic [12:0] k_exp_in = '0;
  bit          k_lat_chk = 1'b0;

  assign k_out_ready = bp_mode ? bp_rdy : 1'b1;
  always @(posedge clk) begin
    #1 bp_rdy = ($urandom_range(0, 1) == 1);
  end

  mo_mul_pipe u_kyber (
    .clk(clk), .rst_n(rst_n),
    .in_valid(k_in_valid), .in_ready(k_in_ready),
    .in_a(k_in_a), .in_b(k_in_b), .in_tag(k_in_tag),
    .out_valid(k_out_valid), .out_ready(k_out_ready),
    .out_data(k_out_data), .out_tag(k_out_tag)
  );

  // ---------------- Dilithium, NORM=1 ----------------
  logic        d_in_valid = 1'b0;
  logic        d_in_ready;
  logic [22:0] d_in_a = '0, d_in_b = '0;
  logic [7:0]  d_in_tag = '0;
  logic        d_out_valid;
  logic [23:0] d_out_data;
  logic [7:0]  d_out_tag;
  logic [23:0] d_exp_in = '0;

  mo_mul_pipe #(.Q_M(DIL_Q_M), .Q_K(DIL_Q_K), .W(DIL_W), .TAG_W(8), .NORM(1)) u_dil (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_a(d_in_a), .in_b(d_in_b), .in_tag(d_in_tag),
    .out_valid(d_out_valid), .out_ready(1'b1),
    .out_data(d_out_data), .out_tag(d_out_tag)
  );

  // ---------------- Kyber, NORM=0 ----------------
  logic        n_in_valid = 1'b0;
  logic        n_in_ready;
  logic [11:0] n_in_a = '0, n_in_b = '0;
  logic [7:0]  n_in_tag = '0;
  logic        n_out_valid;
  logic [12:0] n_out_data;
  logic [7:0]  n_out_tag;
  int          n_out_cnt = 0;

  mo_mul_pipe #(.Q_M(KYBER_Q_M), .Q_K(KYBER_Q_K), .W(KYBER_W), .TAG_W(8), .NORM(0)) u_raw (
    .clk(clk), .rst_n(rst_n),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_a(n_in_a), .in_b(n_in_b), .in_tag(n_in_tag),
    .out_valid(n_out_valid), .out_ready(1'b1),
    .out_data(n_out_data), .out_tag(n_out_tag)
  );

  // ---------------- scoreboards ----------------
  logic [12:0] exp_q[$];
  logic [7:0]  k_tag_q[$];
  int          k_acc_q[$];
  logic [23:0] d_exp_q[$];
  logic [7:0]  d_tag_q[$];
  int          d_acc_q[$];
  logic [11:0] n_a_q[$], n_b_q[$];
  int          n_acc_q[$];

  logic        k_hold = 1'b0;
  logic [12:0] k_hold_d = '0;
  logic [7:0]  k_hold_t = '0;

  always @(negedge clk) begin : k_mon
    int lat;
    if (!rst_n) begin
      exp_q.delete(); k_tag_q.delete(); k_acc_q.delete();
      k_hold = 1'b0;
    end else begin
      if (k_hold) begin
        check("k_stall_valid", k_out_valid, 1);
        check("k_stall_data", k_out_data, k_hold_d);
        check("k_stall_tag", k_out_tag, k_hold_t);
      end
      k_hold   = k_out_valid && !k_out_ready;
      k_hold_d = k_out_data;
      k_hold_t = k_out_tag;
      if (k_out_valid && k_out_ready) begin
        if (exp_q.size() == 0) check("k_spurious_valid", k_out_valid, 0);
        else begin
          check("k_data", k_out_data, exp_q.pop_front());
          check("k_tag", k_out_tag, k_tag_q.pop_front());
          lat = cyc - k_acc_q.pop_front() - 1;
          if (k_lat_chk) check("k_latency", lat, 13);
        end
      end
      if (k_in_valid && k_in_ready) begin
        exp_q.push_back(k_exp_in);
        k_tag_q.push_back(k_in_tag);
        k_acc_q.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin : d_mon
    int lat;
    if (!rst_n) begin
      d_exp_q.delete(); d_tag_q.delete(); d_acc_q.delete();
    end else begin
      if (d_out_valid) begin
        if (d_exp_q.size() == 0) check("d_spurious_valid", d_out_valid, 0);
        else begin
          check("d_data", d_out_data, d_exp_q.pop_front());
          check("d_tag", d_out_tag, d_tag_q.pop_front());
          lat = cyc - d_acc_q.pop_front() - 1;
          check("d_latency", lat, 24);
        end
      end
      if (d_in_valid && d_in_ready) begin
        d_exp_q.push_back(d_exp_in);
        d_tag_q.push_back(d_in_tag);
        d_acc_q.push_back(cyc);
      end
    end
  end

  always @(negedge clk) begin : n_mon
    int     lat;
    longint v, r;
    if (!rst_n) begin
      n_a_q.delete(); n_b_q.delete(); n_acc_q.delete();
    end else begin
      if (n_out_valid) begin
        if (n_a_q.size() == 0) check("n0_spurious_valid", n_out_valid, 0);
        else begin
          v = longint'($signed(n_out_data));
          r = mont_ref(n_a_q.pop_front(), n_b_q.pop_front(), KQ, 12);
          check("n0_range", (v > -KQ && v < KQ), 1);
          check("n0_congruence", ((v % KQ) + KQ) % KQ, r);
          lat = cyc - n_acc_q.pop_front() - 1;
          check("n0_latency", lat, 12);
          n_out_cnt++;
        end
      end
      if (n_in_valid && n_in_ready) begin
        n_a_q.push_back(n_in_a);
        n_b_q.push_back(n_in_b);
        n_acc_q.push_back(cyc);
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic k_send(input logic [11:0] a, input logic [11:0] b,
                        input logic [7:0] tag, input logic [12:0] exp);
    bit acc;
    acc = 1'b0;
    k_in_a = a; k_in_b = b; k_in_tag = tag; k_exp_in = exp;
    k_in_valid = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = k_in_valid && k_in_ready;
      @(posedge clk); #1;
    end
    k_in_valid = 1'b0;
    if (!acc) check("k_send_timeout", acc, 1);
  endtask

  task automatic d_send(input logic [22:0] a, input logic [22:0] b,
                        input logic [7:0] tag, input logic [23:0] exp);
    d_in_a = a; d_in_b = b; d_in_tag = tag; d_exp_in = exp;
    d_in_valid = 1'b1;
    @(posedge clk); #1;
    d_in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || d_exp_q.size() != 0 || n_a_q.size() != 0) && i < 2000) begin
      @(posedge clk); #1;
      i++;
    end
    check("drain_timeout", i < 2000, 1);
  endtask

  // ---------------- directed vectors ----------------
  localparam int NK = 9;
  int kv_a [NK] = '{767, 0,    767,  3328, 1,    3328, 767, 1,   0};
  int kv_b [NK] = '{1234, 3328, 3328, 3328, 1,   1,    767, 767, 0};
  int kv_e [NK] = '{1234, 0,    3328, 2704, 2704, 625, 767, 1,   0};

  localparam int ND = 4;
  int dv_a [ND] = '{8191,    8191,  0,       1};
  int dv_b [ND] = '{8380416, 12345, 8380416, 8191};
  int dv_e [ND] = '{8380416, 12345, 0,       1};

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_k_out_valid", k_out_valid, 0);
    check("rst_k_out_data", k_out_data, 0);
    check("rst_k_out_tag", k_out_tag, 0);
    check("rst_k_in_ready", k_in_ready, 1);
    check("rst_d_out_valid", d_out_valid, 0);
    check("rst_n0_out_valid", n_out_valid, 0);
    check("rst_n0_out_data", n_out_data, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Kyber directed, full rate
    k_lat_chk = 1'b1;
    for (int i = 0; i < NK; i++)
      k_send(12'(kv_a[i]), 12'(kv_b[i]), 8'(i + 1), 13'(kv_e[i]));
    wait_drain();

    // Dilithium directed
    for (int i = 0; i < ND; i++)
      d_send(23'(dv_a[i]), 23'(dv_b[i]), 8'(i + 16), 24'(dv_e[i]));
    wait_drain();

    // NORM=0 random stream against the model
    for (int i = 0; i < 10000; i++) begin
      n_in_a = 12'($urandom_range(0, KQ - 1));
      n_in_b = 12'($urandom_range(0, KQ - 1));
      n_in_tag = 8'(i);
      n_in_valid = 1'b1;
      @(posedge clk); #1;
    end
    n_in_valid = 1'b0;
    wait_drain();
    check("n0_count", n_out_cnt, 10000);

    // Backpressure: random gaps and random out_ready
    k_lat_chk = 1'b0;
    bp_mode = 1'b1;
    for (int i = 0; i < 50; i++) begin
      logic [11:0] a, b;
      a = 12'($urandom_range(0, KQ - 1));
      b = 12'($urandom_range(0, KQ - 1));
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      k_send(a, b, 8'(100 + i), 13'(mont_ref(a, b, KQ, 12)));
    end
    wait_drain();
    bp_mode = 1'b0;
    @(posedge clk); #1;

    // Reset mid-stream, then a lone token
    k_lat_chk = 1'b1;
    for (int i = 0; i < 20; i++) k_send(12'(767), 12'(i * 100), 8'(200 + i), 13'(i * 100));
    check("k_prefill_valid", k_out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("k_rst_out_valid", k_out_valid, 0);
    check("k_rst_out_tag", k_out_tag, 0);
    check("k_rst_in_ready", k_in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    k_send(12'(767), 12'(77), 8'hAA, 13'(77));
    wait_drain();
    repeat (30) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
